// File: rtl/ioctl_sender.sv
// Host-side ioctl transmitter: turns a byte stream into download write strobes and
// runs upload reads, handing the sampled bytes to a valid/ready sink.
module ioctl_sender #(
  parameter int ADDR_W = 25,
  parameter int WR_GAP = 3,
  parameter int UP_LAT = 2
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              cmd_start,
  input  logic              cmd_upload,
  input  logic [7:0]        cmd_index,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              cmd_abort,
  output logic              busy,
  output logic              done,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [7:0]        m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              ioctl_download,
  output logic              ioctl_upload,
  output logic [7:0]        ioctl_index,
  output logic              ioctl_wr,
  output logic [ADDR_W-1:0] ioctl_addr,
  output logic [7:0]        ioctl_dout,
  output logic              ioctl_rd,
  input  logic [7:0]        ioctl_din
);

  // Handshakes: a byte moves on s_valid & s_ready (download) or m_valid & m_ready
  // (upload) at a rising edge; a valid source holds its data until accepted.
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DL_WAIT = 3'd1;
  localparam logic [2:0] S_DL_WR   = 3'd2;
  localparam logic [2:0] S_DL_GAP  = 3'd3;
  localparam logic [2:0] S_UL_RD   = 3'd4;
  localparam logic [2:0] S_UL_WAIT = 3'd5;
  localparam logic [2:0] S_UL_OUT  = 3'd6;
  localparam logic [2:0] S_FIN     = 3'd7;

  localparam int WAIT_MAX = (WR_GAP > UP_LAT) ? WR_GAP : UP_LAT;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [7:0]        index_q, index_d;
  logic [7:0]        dout_q, dout_d;
  logic [7:0]        mdata_q, mdata_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              busy_q, done_q, s_ready_q, m_valid_q;
  logic              download_q, upload_q, wr_q, rd_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    index_d = index_q;
    dout_d  = dout_q;
    mdata_d = mdata_q;
    wait_d  = wait_q;
    if (cmd_abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_start) begin
            if (cmd_len == '0) begin
              state_d = S_FIN;
            end else begin
              index_d = cmd_index;
              len_d   = cmd_len;
              addr_d  = '0;
              cnt_d   = '0;
              state_d = cmd_upload ? S_UL_RD : S_DL_WAIT;
            end
          end
        end
        S_DL_WAIT: begin
          if (s_valid && s_ready_q) begin
            dout_d  = s_data;
            state_d = S_DL_WR;
          end
        end
        S_DL_WR: begin
          // Address steps on leaving the strobe cycle, so it is new from the first gap cycle.
          addr_d  = addr_q + ADDR_W'(1);
          cnt_d   = cnt_q + ADDR_W'(1);
          wait_d  = '0;
          state_d = S_DL_GAP;
        end
        S_DL_GAP: begin
          if (wait_q == WAIT_W'(WR_GAP - 1)) begin
            state_d = (cnt_q == len_q) ? S_FIN : S_DL_WAIT;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
        S_UL_RD: begin
          wait_d  = '0;
          state_d = S_UL_WAIT;
        end
        S_UL_WAIT: begin
          if (wait_q == WAIT_W'(UP_LAT - 1)) begin
            mdata_d = ioctl_din;
            state_d = S_UL_OUT;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
        S_UL_OUT: begin
          if (m_ready) begin
            addr_d  = addr_q + ADDR_W'(1);
            cnt_d   = cnt_q + ADDR_W'(1);
            state_d = (cnt_q + ADDR_W'(1) == len_q) ? S_FIN : S_UL_RD;
          end
        end
        S_FIN:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Strobes and flags are registered decodes of the next state.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      index_q    <= '0;
      dout_q     <= '0;
      mdata_q    <= '0;
      wait_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      s_ready_q  <= 1'b0;
      m_valid_q  <= 1'b0;
      download_q <= 1'b0;
      upload_q   <= 1'b0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      index_q    <= index_d;
      dout_q     <= dout_d;
      mdata_q    <= mdata_d;
      wait_q     <= wait_d;
      busy_q     <= (state_d != S_IDLE);
      done_q     <= (state_d == S_FIN);
      s_ready_q  <= (state_d == S_DL_WAIT);
      m_valid_q  <= (state_d == S_UL_OUT);
      download_q <= (state_d == S_DL_WAIT) || (state_d == S_DL_WR) || (state_d == S_DL_GAP);
      upload_q   <= (state_d == S_UL_RD) || (state_d == S_UL_WAIT) || (state_d == S_UL_OUT);
      wr_q       <= (state_d == S_DL_WR);
      rd_q       <= (state_d == S_UL_RD);
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign s_ready        = s_ready_q;
  assign m_valid        = m_valid_q;
  assign m_data         = mdata_q;
  assign ioctl_download = download_q;
  assign ioctl_upload   = upload_q;
  assign ioctl_index    = index_q;
  assign ioctl_wr       = wr_q;
  assign ioctl_addr     = addr_q;
  assign ioctl_dout     = dout_q;
  assign ioctl_rd       = rd_q;

endmodule

// File: tb/tb_ioctl_sender.sv
// Directed bench for ioctl_sender: cycle-numbered scenarios checked against
// hand-derived strobe cycles, addresses and data.
module tb_ioctl_sender;
  localparam int ADDR_W = 25;

  logic              clk_sys = 1'b0;
  logic              reset_n = 1'b0;
  logic              cmd_start = 1'b0, cmd_upload = 1'b0, cmd_abort = 1'b0;
  logic [7:0]        cmd_index = '0;
  logic [ADDR_W-1:0] cmd_len = '0;
  logic              busy, done, s_ready, m_valid, m_ready = 1'b1, s_valid = 1'b0;
  logic [7:0]        s_data = '0, m_data, ioctl_index, ioctl_dout, ioctl_din = '0;
  logic              ioctl_download, ioctl_upload, ioctl_wr, ioctl_rd;
  logic [ADDR_W-1:0] ioctl_addr;
  logic [56:0]       all_out;

  ioctl_sender #(.ADDR_W(ADDR_W), .WR_GAP(3), .UP_LAT(2)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .cmd_start(cmd_start), .cmd_upload(cmd_upload),
    .cmd_index(cmd_index), .cmd_len(cmd_len), .cmd_abort(cmd_abort), .busy(busy), .done(done),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_rd(ioctl_rd), .ioctl_din(ioctl_din)
  );

  assign all_out = {busy, done, s_ready, m_valid, m_data, ioctl_download, ioctl_upload,
                    ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_rd};

  // Clock / reset
  always #5 clk_sys = ~clk_sys;

  int pass_cnt = 0, total_cnt = 0;
  int cyc = 0;
  logic [7:0] src_tbl [16];
  int src_idx = 0, src_n = 0, sv_lo = 0, sv_hi = 0, mr_lo = 0, mr_hi = 0;
  logic [7:0] core_p1 = '0;

  // Event log, sampled on the falling edge
  int              wr_cyc[$], rd_cyc[$], done_cyc[$], hs_cyc[$];
  logic [ADDR_W-1:0] wr_addr[$], rd_addr[$];
  logic [7:0]      wr_dout[$], m_got[$];
  int              mv_cnt = 0, ul_cnt = 0, dl_fall = -1, ul_fall = -1;
  logic            dl_prev = 1'b0, ul_prev = 1'b0;

  always @(negedge clk_sys) begin
    if (ioctl_wr) begin wr_cyc.push_back(cyc); wr_addr.push_back(ioctl_addr); wr_dout.push_back(ioctl_dout); end
    if (ioctl_rd) begin rd_cyc.push_back(cyc); rd_addr.push_back(ioctl_addr); end
    if (done) done_cyc.push_back(cyc);
    if (m_valid) mv_cnt++;
    if (ioctl_upload) ul_cnt++;
    if (m_valid && m_ready) begin m_got.push_back(m_data); hs_cyc.push_back(cyc); end
    if (dl_prev && !ioctl_download) dl_fall = cyc;
    if (ul_prev && !ioctl_upload) ul_fall = cyc;
    dl_prev = ioctl_download;
    ul_prev = ioctl_upload;
  end

  // Driver tasks
  task automatic drive_src();
    s_valid = (src_idx < src_n) && !(cyc >= sv_lo && cyc < sv_hi);
    s_data  = s_valid ? src_tbl[src_idx] : 8'h00;
    m_ready = !(cyc >= mr_lo && cyc < mr_hi);
  endtask

  // One clock; also advances the byte source and the 2-cycle core read model.
  task automatic step();
    logic hs;
    logic [7:0] p1n, p2n;
    hs  = s_valid && s_ready;
    p1n = ioctl_rd ? (ioctl_addr[7:0] ^ 8'hA5) : core_p1;
    p2n = core_p1;
    @(posedge clk_sys);
    #1;
    cyc++;
    core_p1   = p1n;
    ioctl_din = p2n;
    if (hs) src_idx++;
    drive_src();
  endtask

  task automatic run_to(input int last);
    while (cyc < last) step();
  endtask

  task automatic load_src(input int n, input logic [7:0] b0, b1, b2, b3);
    src_tbl[0] = b0; src_tbl[1] = b1; src_tbl[2] = b2; src_tbl[3] = b3;
    src_idx = 0; src_n = n; sv_lo = 0; sv_hi = 0; mr_lo = 0; mr_hi = 0;
  endtask

  task automatic start_cmd(input int len, input logic [7:0] idx, input logic up);
    wr_cyc.delete(); wr_addr.delete(); wr_dout.delete(); rd_cyc.delete(); rd_addr.delete();
    done_cyc.delete(); m_got.delete(); hs_cyc.delete();
    mv_cnt = 0; ul_cnt = 0; dl_fall = -1; ul_fall = -1;
    cyc = 0;
    cmd_start = 1'b1; cmd_len = ADDR_W'(len); cmd_index = idx; cmd_upload = up;
    drive_src();
    step();
    cmd_start = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    total_cnt++; if (all_out !== '0) $display("FAIL reset_outputs: got %h want 0", all_out); else pass_cnt++;
    reset_n = 1'b1;
    step();
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_download();
    logic [7:0] exp_b [4];
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    load_src(4, 8'h11, 8'h22, 8'h33, 8'h44);
    start_cmd(4, 8'h00, 1'b0);
    total_cnt++; if ({ioctl_download, s_ready} !== 2'b11) $display("FAIL dl_c1_flags: got %b want 11", {ioctl_download, s_ready}); else pass_cnt++;
    run_to(20);
    total_cnt++; if (ioctl_download !== 1'b1) $display("FAIL dl_c20_flag: got %b want 1", ioctl_download); else pass_cnt++;
    run_to(21);
    total_cnt++; if ({done, ioctl_download} !== 2'b10) $display("FAIL dl_c21_done: got %b want 10", {done, ioctl_download}); else pass_cnt++;
    run_to(23);
    total_cnt++; if (wr_cyc.size() !== 4) $display("FAIL dl_wr_count: got %0d want 4", wr_cyc.size()); else pass_cnt++;
    for (int i = 0; i < 4 && i < wr_cyc.size(); i++) begin
      total_cnt++; if (wr_cyc[i] !== 2 + 5 * i) $display("FAIL dl_wr_cycle[%0d]: got %0d want %0d", i, wr_cyc[i], 2 + 5 * i); else pass_cnt++;
      total_cnt++; if (wr_addr[i] !== ADDR_W'(i)) $display("FAIL dl_wr_addr[%0d]: got %0d want %0d", i, wr_addr[i], i); else pass_cnt++;
      total_cnt++; if (wr_dout[i] !== exp_b[i]) $display("FAIL dl_wr_dout[%0d]: got %h want %h", i, wr_dout[i], exp_b[i]); else pass_cnt++;
    end
    total_cnt++; if (done_cyc.size() !== 1) $display("FAIL dl_done_count: got %0d want 1", done_cyc.size()); else pass_cnt++;
    total_cnt++; if (dl_fall !== 21) $display("FAIL dl_fall_cycle: got %0d want 21", dl_fall); else pass_cnt++;
  endtask

  task automatic test_stall();
    int exp_c [4];
    int dl_low;
    exp_c = '{2, 7, 22, 27};
    dl_low = 0;
    load_src(4, 8'hA0, 8'hB1, 8'hC2, 8'hD3);
    sv_lo = 11; sv_hi = 21;
    start_cmd(4, 8'h01, 1'b0);
    while (cyc < 31) begin
      if (!ioctl_download) dl_low++;
      step();
    end
    total_cnt++; if (dl_low !== 0) $display("FAIL stall_flag_drop: got %0d low cycles want 0", dl_low); else pass_cnt++;
    total_cnt++; if (done !== 1'b1) $display("FAIL stall_done_c31: got %b want 1", done); else pass_cnt++;
    total_cnt++; if (wr_cyc.size() !== 4) $display("FAIL stall_wr_count: got %0d want 4", wr_cyc.size()); else pass_cnt++;
    for (int i = 0; i < 4 && i < wr_cyc.size(); i++) begin
      total_cnt++; if (wr_cyc[i] !== exp_c[i]) $display("FAIL stall_wr_cycle[%0d]: got %0d want %0d", i, wr_cyc[i], exp_c[i]); else pass_cnt++;
      total_cnt++; if (wr_addr[i] !== ADDR_W'(i)) $display("FAIL stall_wr_addr[%0d]: got %0d want %0d", i, wr_addr[i], i); else pass_cnt++;
    end
    step();
  endtask

  task automatic test_upload();
    int exp_rc [3];
    int exp_hc [3];
    logic [7:0] exp_m [3];
    exp_rc = '{1, 5, 14};
    exp_hc = '{4, 13, 17};
    exp_m  = '{8'hA5, 8'hA4, 8'hA7};
    load_src(0, 8'h00, 8'h00, 8'h00, 8'h00);
    mr_lo = 8; mr_hi = 13;
    start_cmd(3, 8'h12, 1'b1);
    total_cnt++; if ({ioctl_upload, ioctl_rd} !== 2'b11) $display("FAIL ul_c1_flags: got %b want 11", {ioctl_upload, ioctl_rd}); else pass_cnt++;
    run_to(20);
    total_cnt++; if (rd_cyc.size() !== 3) $display("FAIL ul_rd_count: got %0d want 3", rd_cyc.size()); else pass_cnt++;
    for (int i = 0; i < 3 && i < rd_cyc.size(); i++) begin
      total_cnt++; if (rd_cyc[i] !== exp_rc[i]) $display("FAIL ul_rd_cycle[%0d]: got %0d want %0d", i, rd_cyc[i], exp_rc[i]); else pass_cnt++;
      total_cnt++; if (rd_addr[i] !== ADDR_W'(i)) $display("FAIL ul_rd_addr[%0d]: got %0d want %0d", i, rd_addr[i], i); else pass_cnt++;
    end
    total_cnt++; if (m_got.size() !== 3) $display("FAIL ul_byte_count: got %0d want 3", m_got.size()); else pass_cnt++;
    for (int i = 0; i < 3 && i < m_got.size(); i++) begin
      total_cnt++; if (m_got[i] !== exp_m[i]) $display("FAIL ul_mdata[%0d]: got %h want %h", i, m_got[i], exp_m[i]); else pass_cnt++;
      total_cnt++; if (hs_cyc[i] !== exp_hc[i]) $display("FAIL ul_hs_cycle[%0d]: got %0d want %0d", i, hs_cyc[i], exp_hc[i]); else pass_cnt++;
    end
    total_cnt++; if (mv_cnt !== 8) $display("FAIL ul_mvalid_cycles: got %0d want 8", mv_cnt); else pass_cnt++;
    total_cnt++; if (done_cyc.size() !== 1 || done_cyc[0] !== 18) $display("FAIL ul_done_cycle: got %0d entries want one at 18", done_cyc.size()); else pass_cnt++;
    total_cnt++; if (ul_fall !== 18) $display("FAIL ul_fall_cycle: got %0d want 18", ul_fall); else pass_cnt++;
    total_cnt++; if (ioctl_index !== 8'h12) $display("FAIL ul_index_hold: got %h want 12", ioctl_index); else pass_cnt++;
  endtask

  task automatic test_abort();
    load_src(4, 8'h01, 8'h02, 8'h03, 8'h04);
    start_cmd(8, 8'h02, 1'b0);
    run_to(9);
    cmd_abort = 1'b1;
    step();
    cmd_abort = 1'b0;
    total_cnt++; if ({busy, ioctl_download, s_ready, ioctl_wr} !== 4'b0000) $display("FAIL abort_flags: got %b want 0000", {busy, ioctl_download, s_ready, ioctl_wr}); else pass_cnt++;
    step();
    total_cnt++; if (done_cyc.size() !== 0) $display("FAIL abort_no_done: got %0d want 0", done_cyc.size()); else pass_cnt++;
    total_cnt++; if (wr_cyc.size() !== 2) $display("FAIL abort_wr_count: got %0d want 2", wr_cyc.size()); else pass_cnt++;
    load_src(4, 8'h9A, 8'h9B, 8'h00, 8'h00);
    start_cmd(2, 8'h05, 1'b0);
    total_cnt++; if (ioctl_index !== 8'h05) $display("FAIL restart_index: got %h want 05", ioctl_index); else pass_cnt++;
    run_to(12);
    total_cnt++; if (wr_cyc.size() !== 2 || wr_addr[0] !== 0 || wr_cyc[0] !== 2) $display("FAIL restart_first_wr: got %0d strobes want 2 from addr 0 at cycle 2", wr_cyc.size()); else pass_cnt++;
    total_cnt++; if (done_cyc.size() !== 1 || done_cyc[0] !== 11) $display("FAIL restart_done: got %0d entries want one at 11", done_cyc.size()); else pass_cnt++;
    cmd_start = 1'b1; cmd_abort = 1'b1; cmd_len = ADDR_W'(3);
    step();
    cmd_start = 1'b0; cmd_abort = 1'b0;
    total_cnt++; if ({busy, ioctl_download} !== 2'b00) $display("FAIL abort_beats_start: got %b want 00", {busy, ioctl_download}); else pass_cnt++;
  endtask

  task automatic test_zero_len();
    load_src(0, 8'h00, 8'h00, 8'h00, 8'h00);
    start_cmd(0, 8'h44, 1'b0);
    total_cnt++; if ({done, ioctl_download, ioctl_upload, s_ready, ioctl_wr, ioctl_rd} !== 6'b100000) $display("FAIL zero_c1: got %b want 100000", {done, ioctl_download, ioctl_upload, s_ready, ioctl_wr, ioctl_rd}); else pass_cnt++;
    step();
    total_cnt++; if ({done, busy} !== 2'b00) $display("FAIL zero_c2: got %b want 00", {done, busy}); else pass_cnt++;
    total_cnt++; if (wr_cyc.size() + rd_cyc.size() !== 0) $display("FAIL zero_strobes: got %0d want 0", wr_cyc.size() + rd_cyc.size()); else pass_cnt++;
  endtask

  task automatic test_start_busy();
    load_src(2, 8'h5A, 8'h6B, 8'h00, 8'h00);
    start_cmd(2, 8'h03, 1'b0);
    run_to(4);
    cmd_start = 1'b1; cmd_len = ADDR_W'(9); cmd_index = 8'h07; cmd_upload = 1'b1;
    step();
    cmd_start = 1'b0; cmd_upload = 1'b0;
    run_to(13);
    total_cnt++; if (wr_cyc.size() !== 2) $display("FAIL busy_wr_count: got %0d want 2", wr_cyc.size()); else pass_cnt++;
    total_cnt++; if (ioctl_index !== 8'h03) $display("FAIL busy_index: got %h want 03", ioctl_index); else pass_cnt++;
    total_cnt++; if (ul_cnt !== 0) $display("FAIL busy_no_upload: got %0d want 0", ul_cnt); else pass_cnt++;
    total_cnt++; if (done_cyc.size() !== 1 || done_cyc[0] !== 11) $display("FAIL busy_done: got %0d entries want one at 11", done_cyc.size()); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL busy_after: got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    load_src(4, 8'h11, 8'h22, 8'h33, 8'h44);
    start_cmd(4, 8'h09, 1'b0);
    run_to(2);
    total_cnt++; if (ioctl_wr !== 1'b1) $display("FAIL areset_pre_wr: got %b want 1", ioctl_wr); else pass_cnt++;
    #2;
    reset_n = 1'b0;
    #1;
    total_cnt++; if (all_out !== '0) $display("FAIL areset_outputs: got %h want 0", all_out); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL areset_busy: got %b want 0", busy); else pass_cnt++;
    @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
    step();
    step();
    total_cnt++; if ({busy, ioctl_wr, ioctl_download} !== 3'b000) $display("FAIL areset_stays_idle: got %b want 000", {busy, ioctl_wr, ioctl_download}); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_download();
    test_stall();
    test_upload();
    test_abort();
    test_zero_len();
    test_start_busy();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
